// File: rtl/noise_pkg.sv
// Shared constants, FSM encoding and seed helper for the latent noise source.
package noise_pkg;

    localparam logic [15:0] Q15_ONE_M    = 16'h7FFF;
    localparam logic [15:0] Q15_MIN      = 16'h8000;
    localparam logic [15:0] Q15_MIN_SYM  = 16'h8001;
    localparam logic [31:0] TAPS_DEFAULT = 32'h80200003;
    localparam logic [31:0] SEED_DEFAULT = 32'hACE12468;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN0  = 2'd1,
        GEN1  = 2'd2,
        VALID = 2'd3
    } state_t;

    // A zero seed would lock the LFSR, so it is replaced by the fallback.
    function automatic logic [31:0] seed_or_default(input logic [31:0] seed,
                                                    input logic [31:0] fallback);
        return (seed == 32'h0000_0000) ? fallback : seed;
    endfunction

endpackage

// File: rtl/lfsr_galois_step16.sv
// Sixteen Galois LFSR steps unrolled into one combinational evaluation.
module lfsr_galois_step16
    import noise_pkg::*;
#(
    parameter logic [31:0] TAPS = TAPS_DEFAULT
) (
    input  logic [31:0] lfsr,
    output logic [31:0] next
);

    logic [31:0] s_s;

    // Unrolled shift-and-xor chain
    always_comb begin
        s_s = lfsr;
        for (int i = 0; i < 16; i++) begin
            if (s_s[0]) begin
                s_s = (s_s >> 1) ^ TAPS;
            end else begin
                s_s = s_s >> 1;
            end
        end
        next = s_s;
    end

endmodule

// File: rtl/latent_noise_source_q15.sv
// Latent-vector source: two LFSR draws form one Q1.15 pair, handed off over valid/ready.
module latent_noise_source_q15
    import noise_pkg::*;
#(
    parameter int          LFSR_W       = 32,
    parameter logic [31:0] TAPS         = TAPS_DEFAULT,
    parameter logic [31:0] DEFAULT_SEED = SEED_DEFAULT,
    parameter int          SCALE_SHIFT  = 0,
    parameter bit          SYMMETRIC    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    input  logic        noise_ready,
    output logic        noise_valid,
    output logic [15:0] noise_0,
    output logic [15:0] noise_1,
    output logic [15:0] pair_count
);

    state_t             state_r;
    state_t             state_next_s;
    logic [LFSR_W-1:0]  lfsr_r;
    logic [31:0]        lfsr_next_s;
    logic [15:0]        raw_s;
    logic signed [15:0] sample_s;
    logic [15:0]        pair_count_r;
    logic               advance_s;
    logic               cap0_s;
    logic               cap1_s;
    logic               xfer_s;

    lfsr_galois_step16 #(.TAPS(TAPS)) u_step (
        .lfsr (lfsr_r),
        .next (lfsr_next_s)
    );

    // Map the low half of the next LFSR state to a scaled Q1.15 sample
    always_comb begin
        if (SYMMETRIC && (lfsr_next_s[15:0] == Q15_MIN)) begin
            raw_s = Q15_MIN_SYM;
        end else begin
            raw_s = lfsr_next_s[15:0];
        end
        sample_s = $signed(raw_s) >>> SCALE_SHIFT;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next_s = state_r;
        advance_s    = 1'b0;
        cap0_s       = 1'b0;
        cap1_s       = 1'b0;
        xfer_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = GEN0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GEN0: begin
                advance_s    = 1'b1;
                cap0_s       = 1'b1;
                state_next_s = GEN1;
            end
            GEN1: begin
                advance_s    = 1'b1;
                cap1_s       = 1'b1;
                state_next_s = VALID;
            end
            VALID: begin
                if (noise_ready) begin
                    xfer_s       = 1'b1;
                    state_next_s = enable ? GEN0 : IDLE;
                end else begin
                    state_next_s = VALID;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, LFSR and registered outputs; seed_load restarts and drops any pending pair
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            lfsr_r       <= DEFAULT_SEED;
            noise_valid  <= 1'b0;
            noise_0      <= 16'h0000;
            noise_1      <= 16'h0000;
            pair_count_r <= 16'h0000;
        end else if (seed_load) begin
            state_r      <= IDLE;
            lfsr_r       <= seed_or_default(seed_in, DEFAULT_SEED);
            noise_valid  <= 1'b0;
            pair_count_r <= 16'h0000;
        end else begin
            state_r      <= state_next_s;
            noise_valid  <= (state_next_s == VALID);
            pair_count_r <= pair_count_r + (xfer_s ? 16'd1 : 16'd0);
            if (advance_s) begin
                lfsr_r <= lfsr_next_s;
            end
            if (cap0_s) begin
                noise_0 <= sample_s;
            end
            if (cap1_s) begin
                noise_1 <= sample_s;
            end
        end
    end

    assign pair_count = pair_count_r;

endmodule

// File: tb/tb_latent_noise_source_q15.sv
// Self-checking bench for latent_noise_source_q15 against an arithmetic reference model.
module tb_latent_noise_source_q15;
    import noise_pkg::*;

    logic        clk = 1'b0;
    logic        rst, enable, seed_load, noise_ready;
    logic [31:0] seed_in;
    logic        noise_valid;
    logic [15:0] noise_0, noise_1, pair_count;
    logic        enable2, seed_load2, noise_ready2;
    logic [31:0] seed_in2;
    logic        noise_valid2;
    logic [15:0] noise_0_2, noise_1_2, pair_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latent_noise_source_q15 dut (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
        .noise_ready(noise_ready), .noise_valid(noise_valid), .noise_0(noise_0),
        .noise_1(noise_1), .pair_count(pair_count)
    );

    latent_noise_source_q15 #(.SCALE_SHIFT(2), .SYMMETRIC(1'b1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .seed_load(seed_load2), .seed_in(seed_in2),
        .noise_ready(noise_ready2), .noise_valid(noise_valid2), .noise_0(noise_0_2),
        .noise_1(noise_1_2), .pair_count(pair_count2)
    );

    typedef struct {
        logic [31:0] seed;
        logic [15:0] a0, a1, b0, b1;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [31:0] step16_m(input logic [31:0] s);
        for (int k = 0; k < 16; k++)
            s = s[0] ? ((s >> 1) ^ TAPS_DEFAULT) : (s >> 1);
        return s;
    endfunction

    // Undo sixteen steps: a set MSB can only come from the tap term.
    function automatic logic [31:0] inv16_m(input logic [31:0] t);
        for (int k = 0; k < 16; k++)
            t = t[31] ? (((t ^ TAPS_DEFAULT) << 1) | 32'd1) : (t << 1);
        return t;
    endfunction

    // Symmetric clamp then floor division by 2^sh, in plain integers.
    function automatic logic [15:0] map_m(input logic [15:0] raw, input int sh);
        int v, d, q;
        v = int'($signed(raw));
        if (v == -32768) v = -32767;
        d = 32'sd1 << sh;
        if (v >= 0) q = v / d;
        else q = -((-v + d - 1) / d);
        return q[15:0];
    endfunction

    function automatic logic [63:0] pair_m(input logic [31:0] s, input int sh);
        logic [31:0] s1, s2;
        s1 = step16_m(s);
        s2 = step16_m(s1);
        return {s2, map_m(s1[15:0], sh), map_m(s2[15:0], sh)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!noise_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_valid", 32'(noise_valid), 32'd1);
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_in = s;
        seed_load = 1'b1;
        enable = 1'b0;
        noise_ready = 1'b0;
        tick();
        seed_load = 1'b0;
    endtask

    logic [31:0] m_lfsr, rs, t0;
    logic [15:0] e0, e1;
    logic        pend, hold;
    int          mc;

    initial begin
        rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = 32'd0; noise_ready = 1'b0;
        enable2 = 1'b0; seed_load2 = 1'b0; seed_in2 = 32'd0; noise_ready2 = 1'b0;

        tbl[0].seed = 32'h0000_0000;
        tbl[1].seed = 32'h0000_0001;
        tbl[2].seed = SEED_DEFAULT;
        tbl[3].seed = 32'hFFFF_FFFF;
        tbl[4].seed = 32'h8000_0000;
        tbl[5].seed = $urandom | 32'd1;
        foreach (tbl[i]) begin
            m_lfsr = (tbl[i].seed == 32'd0) ? SEED_DEFAULT : tbl[i].seed;
            {m_lfsr, tbl[i].a0, tbl[i].a1} = pair_m(m_lfsr, 0);
            {m_lfsr, tbl[i].b0, tbl[i].b1} = pair_m(m_lfsr, 0);
        end

        // reset and first-pair latency
        repeat (2) tick();
        chk("rst_valid", 32'(noise_valid), 32'd0);
        chk("rst_n0", 32'(noise_0), 32'd0);
        chk("rst_n1", 32'(noise_1), 32'd0);
        chk("rst_count", 32'(pair_count), 32'd0);
        rst = 1'b0; enable = 1'b1; noise_ready = 1'b1;
        m_lfsr = SEED_DEFAULT;
        tick(); chk("lat_edge1", 32'(noise_valid), 32'd0);
        tick(); chk("lat_edge2", 32'(noise_valid), 32'd0);
        tick(); chk("lat_edge3", 32'(noise_valid), 32'd1);
        {m_lfsr, e0, e1} = pair_m(m_lfsr, 0);
        chk("first_n0", 32'(noise_0), 32'(e0));
        chk("first_n1", 32'(noise_1), 32'(e1));
        tick();
        chk("first_count", 32'(pair_count), 32'd1);
        chk("first_drop", 32'(noise_valid), 32'd0);
        tick();
        tick(); chk("thru_valid", 32'(noise_valid), 32'd1);
        {m_lfsr, e0, e1} = pair_m(m_lfsr, 0);
        noise_ready = 1'b0;

        // backpressure
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(noise_valid), 32'd1);
            chk("bp_n0", 32'(noise_0), 32'(e0));
            chk("bp_n1", 32'(noise_1), 32'(e1));
            chk("bp_count", 32'(pair_count), 32'd1);
            tick();
        end

        // handshake with enable low parks the FSM
        noise_ready = 1'b1; enable = 1'b0;
        tick();
        chk("bp_release_count", 32'(pair_count), 32'd2);
        chk("idle_drop", 32'(noise_valid), 32'd0);
        noise_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_hold", 32'(noise_valid), 32'd0);
        end
        enable = 1'b1;
        repeat (3) tick();
        chk("resume_valid", 32'(noise_valid), 32'd1);
        {m_lfsr, e0, e1} = pair_m(m_lfsr, 0);
        chk("frozen_n0", 32'(noise_0), 32'(e0));
        chk("frozen_n1", 32'(noise_1), 32'(e1));

        // seed_load beats a simultaneous handshake
        rs = $urandom | 32'd1;
        seed_in = rs; seed_load = 1'b1; noise_ready = 1'b1; enable = 1'b0;
        tick();
        seed_load = 1'b0; noise_ready = 1'b0;
        chk("sl_valid", 32'(noise_valid), 32'd0);
        chk("sl_count", 32'(pair_count), 32'd0);
        repeat (2) begin
            tick();
            chk("sl_idle", 32'(noise_valid), 32'd0);
        end
        enable = 1'b1;
        tick(); tick();
        chk("sl_lat2", 32'(noise_valid), 32'd0);
        tick();
        chk("sl_lat3", 32'(noise_valid), 32'd1);
        {m_lfsr, e0, e1} = pair_m(rs, 0);
        chk("sl_n0", 32'(noise_0), 32'(e0));
        chk("sl_n1", 32'(noise_1), 32'(e1));

        // seed table
        foreach (tbl[i]) begin
            load_seed(tbl[i].seed);
            chk("tbl_count0", 32'(pair_count), 32'd0);
            enable = 1'b1;
            wait_valid(10);
            chk("tbl_a0", 32'(noise_0), 32'(tbl[i].a0));
            chk("tbl_a1", 32'(noise_1), 32'(tbl[i].a1));
            noise_ready = 1'b1;
            tick();
            noise_ready = 1'b0;
            chk("tbl_count1", 32'(pair_count), 32'd1);
            wait_valid(10);
            chk("tbl_b0", 32'(noise_0), 32'(tbl[i].b0));
            chk("tbl_b1", 32'(noise_1), 32'(tbl[i].b1));
        end

        // random enable/ready traffic
        rs = $urandom;
        load_seed(rs);
        m_lfsr = (rs == 32'd0) ? SEED_DEFAULT : rs;
        mc = 0; pend = 1'b0; hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk("rand_count", 32'(pair_count), 32'(mc[15:0]));
            if (hold) chk("rand_hold", 32'(noise_valid), 32'd1);
            if (noise_valid) begin
                if (!pend) begin
                    {m_lfsr, e0, e1} = pair_m(m_lfsr, 0);
                    pend = 1'b1;
                end
                chk("rand_n0", 32'(noise_0), 32'(e0));
                chk("rand_n1", 32'(noise_1), 32'(e1));
            end
            enable = ($urandom_range(0, 3) != 0);
            noise_ready = $urandom_range(0, 1) != 0;
            hold = noise_valid && !noise_ready;
            if (noise_valid && noise_ready) begin
                pend = 1'b0;
                mc++;
            end
            tick();
        end

        // pair_count wrap
        load_seed(SEED_DEFAULT);
        enable = 1'b1;
        wait_valid(10);
        force dut.pair_count_r = 16'hFFFF;
        tick();
        release dut.pair_count_r;
        chk("wrap_pre", 32'(pair_count), 32'h0000_FFFF);
        noise_ready = 1'b1;
        tick();
        noise_ready = 1'b0;
        chk("wrap_count", 32'(pair_count), 32'd0);

        // reset mid-generation and mid-valid
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(noise_valid), 32'd0);
        chk("mid_rst_n0", 32'(noise_0), 32'd0);
        chk("mid_rst_n1", 32'(noise_1), 32'd0);
        chk("mid_rst_count", 32'(pair_count), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_valid", 32'(noise_valid), 32'd1);
        {m_lfsr, e0, e1} = pair_m(SEED_DEFAULT, 0);
        chk("post_rst_n0", 32'(noise_0), 32'(e0));
        chk("post_rst_n1", 32'(noise_1), 32'(e1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("valid_rst_valid", 32'(noise_valid), 32'd0);
        chk("valid_rst_n0", 32'(noise_0), 32'd0);
        enable = 1'b0;

        // scaled instance: forced raw extremes
        t0 = {16'h5A5A, Q15_MIN};
        seed_in2 = inv16_m(t0); seed_load2 = 1'b1;
        tick();
        seed_load2 = 1'b0; enable2 = 1'b1;
        repeat (3) tick();
        chk("scale_valid", 32'(noise_valid2), 32'd1);
        chk("scale_min", 32'(noise_0_2), 32'h0000_E000);
        chk("scale_n1", 32'(noise_1_2), 32'(map_m(step16_m(t0) & 32'h0000_FFFF, 2)));
        t0 = {16'hA5A5, Q15_ONE_M};
        seed_in2 = inv16_m(t0); seed_load2 = 1'b1; enable2 = 1'b0;
        tick();
        seed_load2 = 1'b0; enable2 = 1'b1;
        repeat (3) tick();
        chk("scale_max", 32'(noise_0_2), 32'h0000_1FFF);
        chk("scale_count", 32'(pair_count2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
